// File: rtl/arbiter_types.sv
// Shared types and select encodings for the I/D-cache to L2 arbiter slice.
// The datapath address mux and response decoder use the same select constants.
package arbiter_types;

    typedef enum logic [1:0] {
        ARB_IDLE    = 2'd0,
        ARB_SERVE_I = 2'd1,
        ARB_SERVE_D = 2'd2
    } arb_state_t;

    localparam logic ARB_SEL_ICACHE = 1'b0;
    localparam logic ARB_SEL_DCACHE = 1'b1;

    localparam int unsigned PERF_CNT_W = 32;

endpackage : arbiter_types

// File: rtl/arbiter_control_if.sv
// Handshake bundle between the two caches, the arbiter control and L2.
// slave  : arbiter side (takes cache strobes and L2 response, drives selects/strobes)
// master : environment side (caches + L2)
// Optional: ARBITER_PERF_EN adds icache_grant_count / dcache_grant_count.
interface arbiter_control_if;

    logic        Icache_pmem_read;
    logic        Dcache_pmem_read;
    logic        Dcache_pmem_write;
    logic        l2cache_mem_resp;
    logic        arbiter_addr_mux_sel;
    logic        decoder_sel;
    logic        l2cache_pmem_read;
    logic        l2cache_pmem_write;
`ifdef ARBITER_PERF_EN
    logic [31:0] icache_grant_count;
    logic [31:0] dcache_grant_count;
`endif

    modport slave (
        input  Icache_pmem_read,
        input  Dcache_pmem_read,
        input  Dcache_pmem_write,
        input  l2cache_mem_resp,
        output arbiter_addr_mux_sel,
        output decoder_sel,
        output l2cache_pmem_read,
        output l2cache_pmem_write
`ifdef ARBITER_PERF_EN
        ,
        output icache_grant_count,
        output dcache_grant_count
`endif
    );

    modport master (
        output Icache_pmem_read,
        output Dcache_pmem_read,
        output Dcache_pmem_write,
        output l2cache_mem_resp,
        input  arbiter_addr_mux_sel,
        input  decoder_sel,
        input  l2cache_pmem_read,
        input  l2cache_pmem_write
`ifdef ARBITER_PERF_EN
        ,
        input  icache_grant_count,
        input  dcache_grant_count
`endif
    );

endinterface : arbiter_control_if

// File: rtl/arbiter_starve_counter.sv
// Saturating counter of consecutive D-cache grants taken while the I-cache waits.
// Ports: clk, rst (sync, active-high), i_inc (count one D grant), i_clr (I grant),
//        o_at_limit (count has reached STARVE_LIMIT).
module arbiter_starve_counter #(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic clk,
    input  logic rst,
    input  logic i_inc,
    input  logic i_clr,
    output logic o_at_limit
);

    localparam int unsigned CNT_W = $clog2(STARVE_LIMIT + 1);

    logic [CNT_W-1:0] r_cnt;

    assign o_at_limit = (r_cnt == CNT_W'(STARVE_LIMIT));

    // Clear wins; increment holds at the limit instead of wrapping.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (i_clr) begin
            r_cnt <= '0;
        end else if (i_inc && !o_at_limit) begin
            r_cnt <= r_cnt + CNT_W'(1);
        end
    end

endmodule : arbiter_starve_counter

// File: rtl/arbiter_control.sv
// Grants the shared L2 port to the I-cache or D-cache, one transaction at a time.
// D-cache has priority unless the I-cache has waited through STARVE_LIMIT D grants.
// Ports: clk, rst (sync, active-high), bus (arbiter_control_if.slave).
// Optional: ARBITER_PERF_EN adds 32-bit wrapping grant counters per requester.
module arbiter_control
    import arbiter_types::*;
#(
    parameter int unsigned STARVE_LIMIT = 4
) (
    input  logic               clk,
    input  logic               rst,
    arbiter_control_if.slave   bus
);

    arb_state_t r_state;
    logic       w_i_req;
    logic       w_d_req;
    logic       w_at_limit;
    logic       w_grant_i;
    logic       w_grant_d;
    logic       w_in_d;

    assign w_i_req = bus.Icache_pmem_read;
    assign w_d_req = bus.Dcache_pmem_read | bus.Dcache_pmem_write;

    // Arbitration decision, only meaningful while idle.
    assign w_grant_d = (r_state == ARB_IDLE) && w_d_req && !(w_i_req && w_at_limit);
    assign w_grant_i = (r_state == ARB_IDLE) && !w_grant_d && w_i_req;

    arbiter_starve_counter #(
        .STARVE_LIMIT (STARVE_LIMIT)
    ) u_starve (
        .clk        (clk),
        .rst        (rst),
        .i_inc      (w_grant_d && w_i_req),
        .i_clr      (w_grant_i),
        .o_at_limit (w_at_limit)
    );

    // Grant FSM: a grant ends on the L2 response or when its requester aborts.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ARB_IDLE;
        end else begin
            case (r_state)
                ARB_IDLE: begin
                    if (w_grant_d) begin
                        r_state <= ARB_SERVE_D;
                    end else if (w_grant_i) begin
                        r_state <= ARB_SERVE_I;
                    end
                end
                ARB_SERVE_I: begin
                    if (bus.l2cache_mem_resp || !w_i_req) begin
                        r_state <= ARB_IDLE;
                    end
                end
                ARB_SERVE_D: begin
                    if (bus.l2cache_mem_resp || !w_d_req) begin
                        r_state <= ARB_IDLE;
                    end
                end
                default: r_state <= ARB_IDLE;
            endcase
        end
    end

    // Selects follow the state; strobes forward the granted requester live.
    assign w_in_d                   = (r_state == ARB_SERVE_D);
    assign bus.arbiter_addr_mux_sel = w_in_d ? ARB_SEL_DCACHE : ARB_SEL_ICACHE;
    assign bus.decoder_sel          = w_in_d ? ARB_SEL_DCACHE : ARB_SEL_ICACHE;
    assign bus.l2cache_pmem_read    = (r_state == ARB_SERVE_I) ? bus.Icache_pmem_read :
                                      w_in_d                   ? bus.Dcache_pmem_read : 1'b0;
    assign bus.l2cache_pmem_write   = w_in_d & bus.Dcache_pmem_write;

`ifdef ARBITER_PERF_EN
    logic [PERF_CNT_W-1:0] r_icache_grant_count;
    logic [PERF_CNT_W-1:0] r_dcache_grant_count;

    // Count entries into each serve state; natural 32-bit wrap.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_icache_grant_count <= '0;
            r_dcache_grant_count <= '0;
        end else begin
            if (w_grant_i) begin
                r_icache_grant_count <= r_icache_grant_count + PERF_CNT_W'(1);
            end
            if (w_grant_d) begin
                r_dcache_grant_count <= r_dcache_grant_count + PERF_CNT_W'(1);
            end
        end
    end

    assign bus.icache_grant_count = r_icache_grant_count;
    assign bus.dcache_grant_count = r_dcache_grant_count;
`endif

endmodule : arbiter_control

// File: tb/tb_arbiter_control.sv
// Directed bench for arbiter_control (STARVE_LIMIT = 2).
// Output vector checked as {addr_mux_sel, decoder_sel, l2_read, l2_write}.
module tb_arbiter_control;

    logic clk;
    logic rst;
    int   n_cmp;
    int   n_fail;

    arbiter_control_if bus ();

    arbiter_control #(
        .STARVE_LIMIT (2)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    logic [3:0] w_outs;
    assign w_outs = {bus.arbiter_addr_mux_sel, bus.decoder_sel,
                     bus.l2cache_pmem_read, bus.l2cache_pmem_write};

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Settle combinational outputs after driving inputs, then compare.
    task automatic chk_outs(input string tag, input logic [3:0] exp);
        #1;
        chk(tag, 32'(w_outs), 32'(exp));
    endtask

    initial begin
        logic [3:0] starve_seq [6];
        n_cmp  = 0;
        n_fail = 0;
        starve_seq[0] = 4'b1110; starve_seq[1] = 4'b1110; starve_seq[2] = 4'b0010;
        starve_seq[3] = 4'b1110; starve_seq[4] = 4'b1110; starve_seq[5] = 4'b0010;

        rst = 1'b1;
        bus.Icache_pmem_read  = 1'b0;
        bus.Dcache_pmem_read  = 1'b0;
        bus.Dcache_pmem_write = 1'b0;
        bus.l2cache_mem_resp  = 1'b0;
        cyc();
        cyc();
        chk_outs("reset_outs", 4'b0000);
`ifdef ARBITER_PERF_EN
        chk("reset_icnt", bus.icache_grant_count, 32'd0);
        chk("reset_dcnt", bus.dcache_grant_count, 32'd0);
`endif
        rst = 1'b0;

        // Idle, no requests, for 10 cycles.
        for (int i = 0; i < 10; i++) begin
            cyc();
            chk_outs("idle_quiet", 4'b0000);
        end

        // I-cache read alone: grant next cycle, held 4 cycles until resp.
        cyc();
        bus.Icache_pmem_read = 1'b1;
        chk_outs("i_req_same_cycle", 4'b0000);
        for (int k = 0; k < 4; k++) begin
            cyc();
            if (k == 3) bus.l2cache_mem_resp = 1'b1;
            chk_outs("i_serve", 4'b0010);
        end
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        bus.Icache_pmem_read = 1'b0;
        chk_outs("i_done_idle", 4'b0000);

        // Response while idle is ignored.
        bus.l2cache_mem_resp = 1'b1;
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        chk_outs("resp_in_idle", 4'b0000);

        // I and D together: D first, dead cycle, then I.
        bus.Icache_pmem_read = 1'b1;
        bus.Dcache_pmem_read = 1'b1;
        cyc();
        chk_outs("both_d_first", 4'b1110);
        bus.l2cache_mem_resp = 1'b1;
        chk_outs("both_d_resp", 4'b1110);
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        bus.Dcache_pmem_read = 1'b0;
        chk_outs("both_dead_cycle", 4'b0000);
        cyc();
        chk_outs("both_then_i", 4'b0010);
        bus.l2cache_mem_resp = 1'b1;
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        bus.Icache_pmem_read = 1'b0;
        chk_outs("both_end_idle", 4'b0000);

        // Fresh reset, then starvation pattern with both held high.
        rst = 1'b1;
        cyc();
        rst = 1'b0;
        bus.Icache_pmem_read = 1'b1;
        bus.Dcache_pmem_read = 1'b1;
        for (int g = 0; g < 6; g++) begin
            cyc();
            chk_outs($sformatf("starve_grant%0d", g), starve_seq[g]);
            bus.l2cache_mem_resp = 1'b1;
            cyc();
            bus.l2cache_mem_resp = 1'b0;
            chk_outs($sformatf("starve_dead%0d", g), 4'b0000);
        end
        bus.Icache_pmem_read = 1'b0;
        bus.Dcache_pmem_read = 1'b0;

        // One more D-only and I-only grant: totals I=3, D=5 since reset.
        bus.Dcache_pmem_read = 1'b1;
        cyc();
        chk_outs("d_only", 4'b1110);
        bus.l2cache_mem_resp = 1'b1;
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        bus.Dcache_pmem_read = 1'b0;
        chk_outs("d_only_end", 4'b0000);
        bus.Icache_pmem_read = 1'b1;
        cyc();
        chk_outs("i_only", 4'b0010);
        bus.l2cache_mem_resp = 1'b1;
        cyc();
        bus.l2cache_mem_resp = 1'b0;
        bus.Icache_pmem_read = 1'b0;
        chk_outs("i_only_end", 4'b0000);
`ifdef ARBITER_PERF_EN
        chk("perf_icnt", bus.icache_grant_count, 32'd3);
        chk("perf_dcnt", bus.dcache_grant_count, 32'd5);
`endif

        // D write aborted without response.
        bus.Dcache_pmem_write = 1'b1;
        cyc();
        chk_outs("dw_grant", 4'b1101);
        bus.Dcache_pmem_write = 1'b0;
        chk_outs("dw_abort_live", 4'b1100);
        cyc();
        chk_outs("dw_abort_idle", 4'b0000);

        // D write granted, reset mid-grant.
        bus.Dcache_pmem_write = 1'b1;
        cyc();
        chk_outs("dw2_grant", 4'b1101);
        rst = 1'b1;
        cyc();
        chk_outs("rst_mid_grant", 4'b0000);
`ifdef ARBITER_PERF_EN
        chk("rst_icnt", bus.icache_grant_count, 32'd0);
        chk("rst_dcnt", bus.dcache_grant_count, 32'd0);
`endif
        rst = 1'b0;
        bus.Dcache_pmem_write = 1'b0;
        cyc();
        chk_outs("post_rst_idle", 4'b0000);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule : tb_arbiter_control
